// File: rtl/mem_access_ctrl.sv
// Data-side memory access controller: issues one SRAM-like bus transaction per
// load/store from execute, returns the raw read word and stalls the pipeline meanwhile.
module mem_access_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic        mem_req_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] reg2_i,
   input  logic        exception_i,
   input  logic        LLbit_i,
   input  logic        flush_i,
   input  logic        stall_i,
   output logic        data_req_o,
   output logic        data_wr_o,
   output logic [1:0]  data_size_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   output logic [3:0]  data_wstrb_o,
   input  logic        data_addr_ok_i,
   input  logic        data_data_ok_i,
   input  logic [31:0] data_rdata_i,
   output logic [31:0] mem_data_o,
   output logic        mem_data_valid_o,
   output logic        stallreq_o
);

   localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
   localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
   localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
   localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
   localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
   localparam logic [7:0] EXE_LWL_OP = 8'b11100010;
   localparam logic [7:0] EXE_LWR_OP = 8'b11100110;
   localparam logic [7:0] EXE_LL_OP  = 8'b11110000;
   localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
   localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
   localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
   localparam logic [7:0] EXE_SWL_OP = 8'b11101010;
   localparam logic [7:0] EXE_SWR_OP = 8'b11101110;
   localparam logic [7:0] EXE_SC_OP  = 8'b11111000;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   logic [2:0]  r_state;
   logic        r_cancel;
   logic        r_wr;
   logic        r_is_load;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic [31:0] r_rdata;

   logic        w_is_load;
   logic        w_is_store;
   logic        w_is_sc;
   logic [3:0]  w_strb;
   logic [31:0] w_wdata;
   logic        w_issue;
   logic [1:0]  w_a;

   assign w_a = mem_addr_i[1:0];

   always_comb begin
      w_is_load  = 1'b0;
      w_is_store = 1'b0;
      w_is_sc    = 1'b0;
      w_strb     = 4'b0000;
      w_wdata    = 32'h0;
      case (aluop_i)
         EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
         EXE_LW_OP, EXE_LWL_OP, EXE_LWR_OP, EXE_LL_OP: w_is_load = 1'b1;
         EXE_SB_OP: begin
            w_is_store = 1'b1;
            w_strb     = 4'b0001 << w_a;
            w_wdata    = {4{reg2_i[7:0]}};
         end
         EXE_SH_OP: begin
            w_is_store = 1'b1;
            w_strb     = w_a[1] ? 4'b1100 : 4'b0011;
            w_wdata    = {2{reg2_i[15:0]}};
         end
         EXE_SW_OP: begin
            w_is_store = 1'b1;
            w_strb     = 4'b1111;
            w_wdata    = reg2_i;
         end
         EXE_SC_OP: begin
            w_is_store = 1'b1;
            w_is_sc    = 1'b1;
            w_strb     = 4'b1111;
            w_wdata    = reg2_i;
         end
         EXE_SWL_OP: begin
            w_is_store = 1'b1;
            case (w_a)
               2'b00:   begin w_strb = 4'b0001; w_wdata = {24'h0, reg2_i[31:24]}; end
               2'b01:   begin w_strb = 4'b0011; w_wdata = {16'h0, reg2_i[31:16]}; end
               2'b10:   begin w_strb = 4'b0111; w_wdata = {8'h0, reg2_i[31:8]}; end
               default: begin w_strb = 4'b1111; w_wdata = reg2_i; end
            endcase
         end
         EXE_SWR_OP: begin
            w_is_store = 1'b1;
            case (w_a)
               2'b00:   begin w_strb = 4'b1111; w_wdata = reg2_i; end
               2'b01:   begin w_strb = 4'b1110; w_wdata = {reg2_i[23:0], 8'h0}; end
               2'b10:   begin w_strb = 4'b1100; w_wdata = {reg2_i[15:0], 16'h0}; end
               default: begin w_strb = 4'b1000; w_wdata = {reg2_i[7:0], 24'h0}; end
            endcase
         end
         default: ;
      endcase
   end

   assign w_issue = mem_req_i & (w_is_load | w_is_store) & ~exception_i & ~flush_i
                    & ~(w_is_sc & ~LLbit_i);

   // In IDLE the request is driven straight from execute so addr_ok can land in the issue cycle.
   always_comb begin
      data_req_o       = 1'b0;
      data_wr_o        = 1'b0;
      data_size_o      = 2'b00;
      data_addr_o      = 32'h0;
      data_wdata_o     = 32'h0;
      data_wstrb_o     = 4'b0000;
      mem_data_o       = 32'h0;
      mem_data_valid_o = 1'b0;
      stallreq_o       = 1'b0;
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  data_req_o   = 1'b1;
                  data_wr_o    = w_is_store;
                  data_size_o  = 2'b10;
                  data_addr_o  = {mem_addr_i[31:2], 2'b00};
                  data_wdata_o = w_wdata;
                  data_wstrb_o = w_strb;
                  stallreq_o   = 1'b1;
               end
            end
            S_REQ: begin
               data_req_o   = 1'b1;
               data_wr_o    = r_wr;
               data_size_o  = 2'b10;
               data_addr_o  = r_addr;
               data_wdata_o = r_wdata;
               data_wstrb_o = r_wstrb;
               stallreq_o   = 1'b1;
            end
            S_WAIT: begin
               if (data_data_ok_i) begin
                  mem_data_o       = data_rdata_i;
                  mem_data_valid_o = r_is_load;
               end else begin
                  stallreq_o = 1'b1;
               end
            end
            S_DONE: begin
               mem_data_o       = r_rdata;
               mem_data_valid_o = r_is_load;
            end
            S_DRAIN: stallreq_o = mem_req_i;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cancel  <= 1'b0;
         r_wr      <= 1'b0;
         r_is_load <= 1'b0;
         r_addr    <= 32'h0;
         r_wdata   <= 32'h0;
         r_wstrb   <= 4'b0000;
         r_rdata   <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cancel <= 1'b0;
               if (w_issue) begin
                  r_wr      <= w_is_store;
                  r_is_load <= w_is_load;
                  r_addr    <= {mem_addr_i[31:2], 2'b00};
                  r_wdata   <= w_wdata;
                  r_wstrb   <= w_strb;
                  r_state   <= data_addr_ok_i ? S_WAIT : S_REQ;
               end
            end
            S_REQ: begin
               // A posted request cannot be withdrawn; a flush only marks its response for discard.
               if (data_addr_ok_i) begin
                  r_state  <= (r_cancel | flush_i) ? S_DRAIN : S_WAIT;
                  r_cancel <= 1'b0;
               end else if (flush_i) begin
                  r_cancel <= 1'b1;
               end
            end
            S_WAIT: begin
               if (data_data_ok_i) begin
                  r_rdata <= data_rdata_i;
                  r_state <= (stall_i & ~flush_i) ? S_DONE : S_IDLE;
               end else if (flush_i) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DONE: begin
               if (!stall_i || flush_i) r_state <= S_IDLE;
            end
            S_DRAIN: begin
               if (data_data_ok_i) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, store strobes, addr_ok backpressure,
// flush/drain, downstream stall hold, suppressed issue and reset mid-transaction.
module tb_mem_access_ctrl;

   localparam logic [7:0] OP_LW  = 8'b11100011;
   localparam logic [7:0] OP_SB  = 8'b11101000;
   localparam logic [7:0] OP_SH  = 8'b11101001;
   localparam logic [7:0] OP_SW  = 8'b11101011;
   localparam logic [7:0] OP_SWL = 8'b11101010;
   localparam logic [7:0] OP_SWR = 8'b11101110;
   localparam logic [7:0] OP_SC  = 8'b11111000;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  aluop_i;
   logic        mem_req_i;
   logic [31:0] mem_addr_i;
   logic [31:0] reg2_i;
   logic        exception_i;
   logic        LLbit_i;
   logic        flush_i;
   logic        stall_i;
   logic        data_req_o;
   logic        data_wr_o;
   logic [1:0]  data_size_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic [3:0]  data_wstrb_o;
   logic        data_addr_ok_i;
   logic        data_data_ok_i;
   logic [31:0] data_rdata_i;
   logic [31:0] mem_data_o;
   logic        mem_data_valid_o;
   logic        stallreq_o;

   int          n_vec = 0;
   int          n_fail = 0;
   int          n_acc = 0;
   int          acc0;
   logic [31:0] exp_w;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .aluop_i          (aluop_i),
      .mem_req_i        (mem_req_i),
      .mem_addr_i       (mem_addr_i),
      .reg2_i           (reg2_i),
      .exception_i      (exception_i),
      .LLbit_i          (LLbit_i),
      .flush_i          (flush_i),
      .stall_i          (stall_i),
      .data_req_o       (data_req_o),
      .data_wr_o        (data_wr_o),
      .data_size_o      (data_size_o),
      .data_addr_o      (data_addr_o),
      .data_wdata_o     (data_wdata_o),
      .data_wstrb_o     (data_wstrb_o),
      .data_addr_ok_i   (data_addr_ok_i),
      .data_data_ok_i   (data_data_ok_i),
      .data_rdata_i     (data_rdata_i),
      .mem_data_o       (mem_data_o),
      .mem_data_valid_o (mem_data_valid_o),
      .stallreq_o       (stallreq_o)
   );

   // Accepted bus transactions: request and addr_ok in the same cycle.
   always @(negedge clk) if (!rst && data_req_o && data_addr_ok_i) n_acc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_bus();
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b0;
      data_rdata_i   = 32'h0;
   endtask

   task automatic present(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r);
      mem_req_i  = 1'b1;
      aluop_i    = op;
      mem_addr_i = addr;
      reg2_i     = r;
   endtask

   task automatic retire();
      mem_req_i  = 1'b0;
      aluop_i    = 8'h0;
      mem_addr_i = 32'h0;
      reg2_i     = 32'h0;
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [31:0] exp_addr, input logic [31:0] word);
      exp_q.push_back(word);
      present(OP_LW, addr, 32'h0);
      data_addr_ok_i = 1'b1;
      sample();
      chk("ld_req", data_req_o, 1);
      chk("ld_addr", data_addr_o, exp_addr);
      chk("ld_strb", data_wstrb_o, 0);
      chk("ld_wr", data_wr_o, 0);
      chk("ld_stall_issue", stallreq_o, 1);
      next_cycle();
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b1;
      data_rdata_i   = word;
      sample();
      chk("ld_valid", mem_data_valid_o, 1);
      chk("ld_data", mem_data_o, exp_q.pop_front());
      chk("ld_stall_dataok", stallreq_o, 0);
      next_cycle();
      idle_bus();
      retire();
   endtask

   task automatic do_store(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] r, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
      present(op, addr, r);
      data_addr_ok_i = 1'b1;
      sample();
      chk({tag, "_req"}, data_req_o, 1);
      chk({tag, "_wr"}, data_wr_o, 1);
      chk({tag, "_size"}, data_size_o, 2);
      chk({tag, "_addr"}, data_addr_o, exp_addr);
      chk({tag, "_strb"}, data_wstrb_o, exp_strb);
      chk({tag, "_wdata"}, data_wdata_o, exp_wdata);
      next_cycle();
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b1;
      data_rdata_i   = 32'h5555_5555;
      sample();
      chk({tag, "_novalid"}, mem_data_valid_o, 0);
      chk({tag, "_stall"}, stallreq_o, 0);
      next_cycle();
      idle_bus();
      retire();
   endtask

   initial begin
      rst = 1'b1;
      exception_i = 1'b0;
      LLbit_i = 1'b0;
      flush_i = 1'b0;
      stall_i = 1'b0;
      idle_bus();
      present(OP_LW, 32'h8000_0104, 32'h0);
      data_addr_ok_i = 1'b1;
      sample();
      chk("rst_req", data_req_o, 0);
      chk("rst_stall", stallreq_o, 0);
      chk("rst_valid", mem_data_valid_o, 0);
      chk("rst_data", mem_data_o, 0);
      next_cycle();
      rst = 1'b0;
      retire();
      idle_bus();
      next_cycle();

      do_load(32'h8000_0104, 32'h8000_0104, 32'h1234_5678);

      do_store("sb3", OP_SB, 32'h0000_1003, 32'hAABB_CCDD, 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD);
      do_store("sh2", OP_SH, 32'h0000_1002, 32'hAABB_CCDD, 32'h0000_1000, 4'b1100, 32'hCCDD_CCDD);
      do_store("swl1", OP_SWL, 32'h0000_1001, 32'hAABB_CCDD, 32'h0000_1000, 4'b0011, 32'h0000_AABB);
      do_store("swr2", OP_SWR, 32'h0000_1002, 32'hAABB_CCDD, 32'h0000_1000, 4'b1100, 32'hCCDD_0000);
      LLbit_i = 1'b1;
      do_store("sc_ll1", OP_SC, 32'h0000_6000, 32'h0102_0304, 32'h0000_6000, 4'b1111, 32'h0102_0304);
      LLbit_i = 1'b0;

      // addr_ok withheld three cycles; execute inputs wander to prove the fields are latched
      present(OP_SW, 32'h0000_2000, 32'h1122_3344);
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("hold_req", data_req_o, 1);
         chk("hold_addr", data_addr_o, 32'h0000_2000);
         chk("hold_wdata", data_wdata_o, 32'h1122_3344);
         chk("hold_strb", data_wstrb_o, 4'b1111);
         chk("hold_stall", stallreq_o, 1);
         next_cycle();
         mem_addr_i = 32'h0000_7770 + i;
         reg2_i     = 32'hFFFF_0000 + i;
      end
      data_addr_ok_i = 1'b1;
      sample();
      chk("hold_req_accept", data_req_o, 1);
      chk("hold_addr_accept", data_addr_o, 32'h0000_2000);
      next_cycle();
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b1;
      sample();
      chk("hold_done_stall", stallreq_o, 0);
      next_cycle();
      idle_bus();
      retire();

      // flush while waiting for data, then a new load presented during drain
      present(OP_LW, 32'h0000_3000, 32'h0);
      data_addr_ok_i = 1'b1;
      sample();
      chk("fl_req", data_req_o, 1);
      next_cycle();
      data_addr_ok_i = 1'b0;
      retire();
      flush_i = 1'b1;
      sample();
      chk("fl_wait_valid", mem_data_valid_o, 0);
      chk("fl_wait_stall", stallreq_o, 1);
      next_cycle();
      flush_i = 1'b0;
      present(OP_LW, 32'h0000_4000, 32'h0);
      data_addr_ok_i = 1'b1;
      sample();
      chk("dr_noreq", data_req_o, 0);
      chk("dr_stall", stallreq_o, 1);
      chk("dr_valid", mem_data_valid_o, 0);
      next_cycle();
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b1;
      data_rdata_i   = 32'hDEAD_BEEF;
      sample();
      chk("dr_ok_valid", mem_data_valid_o, 0);
      chk("dr_ok_data", mem_data_o, 0);
      chk("dr_ok_noreq", data_req_o, 0);
      chk("dr_ok_stall", stallreq_o, 1);
      next_cycle();
      idle_bus();
      do_load(32'h0000_4000, 32'h0000_4000, 32'hCAFE_F00D);

      // downstream stall on the data_ok cycle: word held while stalled, one request only
      acc0 = n_acc;
      exp_q.push_back(32'hA5A5_0001);
      present(OP_LW, 32'h0000_5000, 32'h0);
      data_addr_ok_i = 1'b1;
      sample();
      chk("st_req", data_req_o, 1);
      next_cycle();
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b1;
      data_rdata_i   = 32'hA5A5_0001;
      stall_i        = 1'b1;
      exp_w          = exp_q.pop_front();
      sample();
      chk("st_valid0", mem_data_valid_o, 1);
      chk("st_data0", mem_data_o, exp_w);
      chk("st_stall0", stallreq_o, 0);
      next_cycle();
      idle_bus();
      sample();
      chk("st_valid1", mem_data_valid_o, 1);
      chk("st_data1", mem_data_o, exp_w);
      chk("st_noreq1", data_req_o, 0);
      chk("st_stall1", stallreq_o, 0);
      next_cycle();
      stall_i = 1'b0;
      sample();
      chk("st_valid2", mem_data_valid_o, 1);
      chk("st_data2", mem_data_o, exp_w);
      next_cycle();
      retire();
      sample();
      chk("st_valid_end", mem_data_valid_o, 0);
      chk("st_one_req", n_acc - acc0, 1);
      next_cycle();

      // suppressed issue: SC without LL bit, load carrying an exception
      data_addr_ok_i = 1'b1;
      present(OP_SC, 32'h0000_6000, 32'h0102_0304);
      sample();
      chk("sc_ll0_req", data_req_o, 0);
      chk("sc_ll0_stall", stallreq_o, 0);
      next_cycle();
      present(OP_LW, 32'h0000_7000, 32'h0);
      exception_i = 1'b1;
      sample();
      chk("exc_req", data_req_o, 0);
      chk("exc_stall", stallreq_o, 0);
      next_cycle();
      exception_i = 1'b0;
      retire();
      idle_bus();

      // reset while a request is pending
      present(OP_LW, 32'h0000_8000, 32'h0);
      sample();
      chk("mrst_req_before", data_req_o, 1);
      next_cycle();
      rst = 1'b1;
      sample();
      chk("mrst_req_during", data_req_o, 0);
      chk("mrst_stall_during", stallreq_o, 0);
      next_cycle();
      rst = 1'b0;
      retire();
      sample();
      chk("mrst_req_after", data_req_o, 0);
      chk("mrst_stall_after", stallreq_o, 0);
      next_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
